alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one `alu` instance between two requesters: the execute path (requester 0) and the address/branch-target path (requester 1). Arbitration is round-robin. The accepted operation goes through the ALU and the result is captured in a single output register. That result is then returned on the owning requester's response channel under valid/ready backpressure. It sits between the decode/issue logic and the writeback/LSU consumers of the multi-cycle datapath.

## Interface
- `WIDTH`, 32: operand and result width.
- `i_clk`  in  1: clock; all state updates on the rising edge.
- `i_rst`  in  1: synchronous, active-high reset.
- `i_req0_valid`, `i_req1_valid`  in  1 each: requester has an operation.
- `o_req0_ready`, `o_req1_ready`  out  1 each: operation accepted this cycle when valid and ready are both high.
- `i_req0_op`, `i_req1_op`  in  4 each: ALU opcode.
- `i_req0_a`, `i_req0_b`, `i_req1_a`, `i_req1_b`  in  `WIDTH` each: operands.
- `o_rsp0_valid`, `o_rsp1_valid`  out  1 each: result held for requester 0 or 1. At most one is high at a time.
- `i_rsp0_ready`, `i_rsp1_ready`  in  1 each: consumer takes the result.
- `o_rsp_data`  out  `WIDTH`: held result, shared by both response channels.
- `o_busy`  out  1: output register occupied.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 XOR, 5 OR, 6 AND, 7 SLL, 8 SRL, 9 SRA.
  - Opcodes 10–15 produce 0 and are still accepted and returned as a normal response.
- Arithmetic:
  - Results wrap modulo 2^`WIDTH`.
  - Shift amount is `b[4:0]`.
  - SLT and SLTU return 1 or 0 in bit 0, with all upper bits 0.
- FSM has two states: EMPTY and FULL, where FULL means a result is held and `owner` records which requester it belongs to.
- `can_accept = EMPTY | (FULL & rsp_ready[owner])`, so one result can drain and the next operation be accepted in the same cycle.
- Grant:
  - If only one requester is valid, it is granted.
  - If both are valid, the requester other than `last_grant` is granted.
  - `o_reqN_ready = grant_N & can_accept`. Ready depends combinationally on both valids. The requester that is not granted sees ready low.
- On acceptance:
  - The ALU result for the granted operands is registered into `o_rsp_data`.
  - `owner` is set to the granted requester, the state goes to FULL, and `last_grant` is set to the granted requester.
- When the result drains (valid and ready both high) with no new acceptance, the state goes to EMPTY.
- If the consumer that is not the owner asserts ready, it has no effect.
- Request inputs are ignored when not accepted. Requesters must hold op and operands stable while valid and not ready.

## Timing
- Latency is 1 cycle: an operation accepted at edge N has its response valid after edge N, i.e. in cycle N+1.
- Throughput is 1 operation per cycle when the owner's consumer holds ready high.
- Reset values:
  - `o_rsp0_valid`, `o_rsp1_valid`, `o_busy` = 0.
  - `o_rsp_data` = 0.
  - `last_grant` = 1, so requester 0 wins the first tie.
  - State = EMPTY.
- `o_req*_ready` is 0 while `i_rst` is high.
- Reset in the middle of an operation discards any held result. Nothing accepted in the reset cycle is retained.
- Backpressure: while FULL and the owner's ready is low, `o_rsp_data`, `owner` and `o_rspN_valid` hold steady, and both request readies are 0.
- Simultaneous drain and accept: the new result replaces the old one at the same edge, and `o_rspN_valid` may move from one channel to the other with no bubble.
- Tie while the register is blocked: no grant happens and `last_grant` is unchanged, so fairness is preserved.

## Structure
- Package `alu_pkg`:
  - Opcode localparams (`A_ADD` … `A_SRA`) shared with `alu` and the decoder.
  - A one-bit typedef for requester id (`REQ_EXE = 0`, `REQ_AGU = 1`).
- Sub-module: one `alu` instance, fed through a 2:1 operand/op mux selected by the grant. The ALU stays purely combinational.
- All arbitration, the FSM, `owner`, `last_grant` and the output register live in `alu_arbiter`.

## Test plan
- Reset, then req0 only: ADD, a=0x7FFFFFFF, b=1. Expect accept in cycle 0; in cycle 1, `o_rsp0_valid`=1 and data=0x80000000; `o_rsp1_valid`=0.
- Both valid every cycle, both rsp ready high:
  - req0 sends SUB 5−7, req1 sends SLTU 0xFFFFFFFF<1.
  - Expect grants alternating 0,1,0,… starting with 0.
  - Expect responses 0xFFFFFFFE and 0 respectively, one per cycle.
- Backpressure:
  - req1 SRA 0x80000000 by 4 with `i_rsp1_ready`=0 for 3 cycles.
  - Expect data held at 0xF8000000, both request readies 0, `o_busy`=1.
  - On release, drain and next accept occur in the same cycle.
- Opcode 12 from req0. Expect it accepted and the response data = 0.
- Reset asserted while FULL. Expect valids and `o_busy` 0 on the next cycle, and the next tie granted to req0.
- Wrong consumer ready: result owned by req0, only `i_rsp1_ready`=1. Expect no drain and the result held.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, requester ids and arbiter state type
package alu_pkg;

  // ALU opcodes, shared by the alu, the arbiter and the decoder
  localparam logic [3:0] A_ADD  = 4'd0;
  localparam logic [3:0] A_SUB  = 4'd1;
  localparam logic [3:0] A_SLT  = 4'd2;
  localparam logic [3:0] A_SLTU = 4'd3;
  localparam logic [3:0] A_XOR  = 4'd4;
  localparam logic [3:0] A_OR   = 4'd5;
  localparam logic [3:0] A_AND  = 4'd6;
  localparam logic [3:0] A_SLL  = 4'd7;
  localparam logic [3:0] A_SRL  = 4'd8;
  localparam logic [3:0] A_SRA  = 4'd9;

  // Requester identity: execute path and address/branch-target path
  typedef enum logic {
    REQ_EXE = 1'b0,
    REQ_AGU = 1'b1
  } req_id_t;

  // Output register occupancy
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - purely combinational integer ALU
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  // Opcode decode; unused opcodes deliberately yield zero
  always_comb begin
    y_o = '0;
    case (op_i)
      A_ADD:   y_o = a_i + b_i;
      A_SUB:   y_o = a_i - b_i;
      A_SLT:   y_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      A_SLTU:  y_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      A_XOR:   y_o = a_i ^ b_i;
      A_OR:    y_o = a_i | b_i;
      A_AND:   y_o = a_i & b_i;
      A_SLL:   y_o = a_i << shamt;
      A_SRL:   y_o = a_i >> shamt;
      A_SRA:   y_o = $signed(a_i) >>> shamt;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one alu between two requesters
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [3:0]       i_req0_op,
  input  logic [WIDTH-1:0] i_req0_a,
  input  logic [WIDTH-1:0] i_req0_b,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [3:0]       i_req1_op,
  input  logic [WIDTH-1:0] i_req1_a,
  input  logic [WIDTH-1:0] i_req1_b,
  output logic             o_rsp0_valid,
  input  logic             i_rsp0_ready,
  output logic             o_rsp1_valid,
  input  logic             i_rsp1_ready,
  output logic [WIDTH-1:0] o_rsp_data,
  output logic             o_busy
);

  arb_state_t       state_q, state_d;
  req_id_t          owner_q, owner_d;
  req_id_t          last_grant_q, last_grant_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic             grant0, grant1;
  req_id_t          sel;
  logic             owner_ready;
  logic             can_accept;
  logic             accept;
  logic             drain;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y;

  // Grant: a lone requester wins; on a tie the one not granted last time wins
  always_comb begin
    grant0 = i_req0_valid & (~i_req1_valid | (last_grant_q == REQ_AGU));
    grant1 = i_req1_valid & (~i_req0_valid | (last_grant_q == REQ_EXE));
    sel    = grant1 ? REQ_AGU : REQ_EXE;
  end

  // Accept when empty, or when the held result drains in the same cycle
  always_comb begin
    owner_ready  = (owner_q == REQ_AGU) ? i_rsp1_ready : i_rsp0_ready;
    drain        = (state_q == ST_FULL) & owner_ready;
    can_accept   = ~i_rst & ((state_q == ST_EMPTY) | owner_ready);
    o_req0_ready = grant0 & can_accept;
    o_req1_ready = grant1 & can_accept;
    accept       = (grant0 | grant1) & can_accept;
  end

  // Operand/op mux feeding the shared alu
  always_comb begin
    alu_op = (sel == REQ_AGU) ? i_req1_op : i_req0_op;
    alu_a  = (sel == REQ_AGU) ? i_req1_a  : i_req0_a;
    alu_b  = (sel == REQ_AGU) ? i_req1_b  : i_req0_b;
  end

  alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .op_i(alu_op),
    .a_i (alu_a),
    .b_i (alu_b),
    .y_o (alu_y)
  );

  // Next state: a new acceptance overrides a drain so there is no bubble
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    data_d       = data_q;
    if (accept) begin
      state_d      = ST_FULL;
      owner_d      = sel;
      last_grant_d = sel;
      data_d       = alu_y;
    end else if (drain) begin
      state_d = ST_EMPTY;
    end
  end

  // State registers; reset drops any held result and favours requester 0 next
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_EMPTY;
      owner_q      <= REQ_EXE;
      last_grant_q <= REQ_AGU;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
    end
  end

  assign o_busy       = (state_q == ST_FULL);
  assign o_rsp0_valid = (state_q == ST_FULL) & (owner_q == REQ_EXE);
  assign o_rsp1_valid = (state_q == ST_FULL) & (owner_q == REQ_AGU);
  assign o_rsp_data   = data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

  logic        i_clk;
  logic        i_rst;
  logic        i_req0_valid, i_req1_valid;
  logic        o_req0_ready, o_req1_ready;
  logic [3:0]  i_req0_op, i_req1_op;
  logic [31:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
  logic        o_rsp0_valid, o_rsp1_valid;
  logic        i_rsp0_ready, i_rsp1_ready;
  logic [31:0] o_rsp_data;
  logic        o_busy;

  int n_cmp;
  int n_bad;

  logic [3:0]  v_op  [9];
  logic [31:0] v_a   [9];
  logic [31:0] v_b   [9];
  logic [31:0] v_exp [9];

  alu_arbiter #(.WIDTH(32)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req0_valid(i_req0_valid),
    .o_req0_ready(o_req0_ready),
    .i_req0_op   (i_req0_op),
    .i_req0_a    (i_req0_a),
    .i_req0_b    (i_req0_b),
    .i_req1_valid(i_req1_valid),
    .o_req1_ready(o_req1_ready),
    .i_req1_op   (i_req1_op),
    .i_req1_a    (i_req1_a),
    .i_req1_b    (i_req1_b),
    .o_rsp0_valid(o_rsp0_valid),
    .i_rsp0_ready(i_rsp0_ready),
    .o_rsp1_valid(o_rsp1_valid),
    .i_rsp1_ready(i_rsp1_ready),
    .o_rsp_data  (o_rsp_data),
    .o_busy      (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic reset_dut();
    i_rst        = 1'b1;
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    step();
    step();
    i_rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    i_rst = 1'b1;
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    i_req0_op = 4'd0; i_req0_a = 32'd0; i_req0_b = 32'd0;
    i_req1_op = 4'd0; i_req1_a = 32'd0; i_req1_b = 32'd0;
    i_rsp0_ready = 1'b1; i_rsp1_ready = 1'b1;

    v_op  = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd1};
    v_a   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000F0F0, 32'h0000F0F0, 32'h0000F0F0,
              32'h00000001, 32'h80000000, 32'h80000000, 32'h00000000};
    v_b   = '{32'h00000001, 32'h00000001, 32'h0000FF00, 32'h0000FF00, 32'h0000FF00,
              32'h00000023, 32'h0000001F, 32'h00000024, 32'h00000001};
    v_exp = '{32'h00000001, 32'h00000000, 32'h00000FF0, 32'h0000FFF0, 32'h0000F000,
              32'h00000008, 32'h00000001, 32'hF8000000, 32'hFFFFFFFF};

    // reset: a valid request must not be accepted or retained
    step();
    i_req0_valid = 1'b1;
    #1;
    check("rst_rdy0", o_req0_ready, 1'b0);
    step();
    i_rst = 1'b0;
    i_req0_valid = 1'b0;
    #1;
    check("rst_v0", o_rsp0_valid, 1'b0);
    check("rst_v1", o_rsp1_valid, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_data", o_rsp_data, 32'h0);

    // single requester ADD with wrap
    i_req0_valid = 1'b1; i_req0_op = 4'd0; i_req0_a = 32'h7FFFFFFF; i_req0_b = 32'h1;
    #1;
    check("add_rdy0", o_req0_ready, 1'b1);
    step();
    i_req0_valid = 1'b0;
    check("add_v0", o_rsp0_valid, 1'b1);
    check("add_v1", o_rsp1_valid, 1'b0);
    check("add_data", o_rsp_data, 32'h80000000);
    step();
    check("add_drain", o_busy, 1'b0);

    // back-to-back opcode table from requester 0, one result per cycle
    i_req0_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      i_req0_op = v_op[k]; i_req0_a = v_a[k]; i_req0_b = v_b[k];
      #1;
      check("tbl_rdy0", o_req0_ready, 1'b1);
      step();
      check("tbl_v0", o_rsp0_valid, 1'b1);
      check("tbl_data", o_rsp_data, v_exp[k]);
    end
    i_req0_valid = 1'b0;
    step();

    // tie every cycle after reset: grants alternate starting with requester 0
    reset_dut();
    i_req0_valid = 1'b1; i_req0_op = 4'd1; i_req0_a = 32'd5;          i_req0_b = 32'd7;
    i_req1_valid = 1'b1; i_req1_op = 4'd3; i_req1_a = 32'hFFFFFFFF;   i_req1_b = 32'd1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("tie_rdy0", o_req0_ready, (k % 2) == 0);
      check("tie_rdy1", o_req1_ready, (k % 2) == 1);
      step();
      check("tie_v0", o_rsp0_valid, (k % 2) == 0);
      check("tie_v1", o_rsp1_valid, (k % 2) == 1);
      check("tie_data", o_rsp_data, ((k % 2) == 0) ? 32'hFFFFFFFE : 32'h0);
    end
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;
    step();
    check("tie_drain", o_busy, 1'b0);

    // backpressure on requester 1 while a tie waits
    i_rsp1_ready = 1'b0;
    i_req1_valid = 1'b1; i_req1_op = 4'd9; i_req1_a = 32'h80000000; i_req1_b = 32'd4;
    #1;
    check("bp_rdy1", o_req1_ready, 1'b1);
    step();
    i_req1_op = 4'd0; i_req1_a = 32'd1; i_req1_b = 32'd2;
    i_req0_valid = 1'b1; i_req0_op = 4'd12; i_req0_a = 32'd5; i_req0_b = 32'd6;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("bp_data", o_rsp_data, 32'hF8000000);
      check("bp_v1", o_rsp1_valid, 1'b1);
      check("bp_busy", o_busy, 1'b1);
      check("bp_rdy0", o_req0_ready, 1'b0);
      check("bp_rdy1b", o_req1_ready, 1'b0);
      step();
    end
    i_rsp1_ready = 1'b1;
    #1;
    check("rel_rdy0", o_req0_ready, 1'b1);
    check("rel_rdy1", o_req1_ready, 1'b0);
    step();
    check("op12_v0", o_rsp0_valid, 1'b1);
    check("op12_v1", o_rsp1_valid, 1'b0);
    check("op12_data", o_rsp_data, 32'h0);
    i_req0_valid = 1'b0;
    #1;
    check("nxt_rdy1", o_req1_ready, 1'b1);
    step();
    check("nxt_v1", o_rsp1_valid, 1'b1);
    check("nxt_data", o_rsp_data, 32'd3);
    i_req1_valid = 1'b0;
    step();
    check("bp_drain", o_busy, 1'b0);

    // wrong consumer ready does not drain requester 0's result
    i_rsp0_ready = 1'b0; i_rsp1_ready = 1'b1;
    i_req0_valid = 1'b1; i_req0_op = 4'd0; i_req0_a = 32'd10; i_req0_b = 32'd20;
    step();
    i_req0_valid = 1'b0;
    step();
    step();
    check("wc_v0", o_rsp0_valid, 1'b1);
    check("wc_v1", o_rsp1_valid, 1'b0);
    check("wc_data", o_rsp_data, 32'd30);

    // reset while full discards the result; first tie afterwards goes to requester 0
    i_rst = 1'b1;
    i_req1_valid = 1'b1;
    step();
    i_rst = 1'b0;
    i_req1_valid = 1'b0;
    #1;
    check("rf_v0", o_rsp0_valid, 1'b0);
    check("rf_v1", o_rsp1_valid, 1'b0);
    check("rf_busy", o_busy, 1'b0);
    i_rsp0_ready = 1'b1;
    i_req0_valid = 1'b1; i_req1_valid = 1'b1;
    #1;
    check("rf_rdy0", o_req0_ready, 1'b1);
    check("rf_rdy1", o_req1_ready, 1'b0);
    step();
    i_req0_valid = 1'b0; i_req1_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
